// File: rtl/mem_access_if.sv
// mem_access_if: EX-side, writeback and byte-memory signals of the memory-access stage
interface mem_access_if;
  logic        rdy;
  logic        stall_req;
  logic        we_in;
  logic [4:0]  waddr_in;
  logic [31:0] wdata_in;
  logic        ma_we_in;
  logic        ma_re_in;
  logic [2:0]  ma_width_in;
  logic [31:0] ma_addr_in;
  logic [31:0] ma_wdata_in;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  modport master (
    output rdy, we_in, waddr_in, wdata_in, ma_we_in, ma_re_in, ma_width_in, ma_addr_in,
           ma_wdata_in, mem_rdata, mem_ack,
    input  stall_req, we, waddr, wdata, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  rdy, we_in, waddr_in, wdata_in, ma_we_in, ma_re_in, ma_width_in, ma_addr_in,
           ma_wdata_in, mem_rdata, mem_ack,
    output stall_req, we, waddr, wdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: serialises loads/stores into byte transfers, stalling the pipeline until done
module mem_access (
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  logic [1:0]  state_q, state_d, cnt_q, cnt_d, last;
  logic [31:0] rd_buf_q, rd_buf_d, ld_word;
  logic        is_mem, sx, pass, in_acc;
  always_comb begin
    is_mem   = bus.ma_we_in | bus.ma_re_in;
    last     = bus.ma_width_in[1:0] == 2'b00 ? 2'd0 : bus.ma_width_in[1:0] == 2'b01 ? 2'd1 : 2'd3;
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_buf_d = rd_buf_q;
    if (bus.rdy) begin
      if (state_q == IDLE && is_mem) begin
        state_d = ACCESS;
        cnt_d   = 2'd0;
      end else if (state_q == ACCESS && bus.mem_ack) begin
        if (!bus.ma_we_in) rd_buf_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata;
        if (cnt_q == last) state_d = DONE;
        else cnt_d = cnt_q + 2'd1;
      end else if (state_q == DONE) state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      rd_buf_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_buf_q <= rd_buf_d;
    end
  end
  always_comb begin
    sx      = ~bus.ma_width_in[2];
    ld_word = bus.ma_width_in[1:0] == 2'b00 ? {{24{sx & rd_buf_q[7]}}, rd_buf_q[7:0]} :
              bus.ma_width_in[1:0] == 2'b01 ? {{16{sx & rd_buf_q[15]}}, rd_buf_q[15:0]} : rd_buf_q;
    in_acc  = !rst && state_q == ACCESS;
    pass    = !rst && ((state_q == IDLE && !is_mem) || state_q == DONE);
    bus.stall_req = !rst && ((state_q == IDLE && is_mem) || state_q == ACCESS);
    bus.mem_req   = in_acc;
    bus.mem_we    = in_acc && bus.ma_we_in;
    bus.mem_addr  = in_acc ? bus.ma_addr_in + {30'd0, cnt_q} : 32'd0;
    bus.mem_wdata = in_acc ? bus.ma_wdata_in[{cnt_q, 3'b000} +: 8] : 8'd0;
    bus.we        = pass && bus.we_in;
    bus.waddr     = pass ? bus.waddr_in : 5'd0;
    bus.wdata     = !pass ? 32'd0 : (state_q == DONE && !bus.ma_we_in) ? ld_word : bus.wdata_in;
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed checks of pass-through, loads, stores, stalls and reset
module tb_mem_access;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  mem_access_if bus ();
  mem_access dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic we, input logic re, input logic [2:0] w,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic wi, input logic [4:0] wa, input logic [31:0] wd);
    bus.ma_we_in = we; bus.ma_re_in = re; bus.ma_width_in = w;
    bus.ma_addr_in = addr; bus.ma_wdata_in = sdata;
    bus.we_in = wi; bus.waddr_in = wa; bus.wdata_in = wd;
  endtask

  task automatic start_chk(input string tag);
    #1;
    chk({tag, "_start_stall"}, bus.stall_req, 1);
    chk({tag, "_start_req"}, bus.mem_req, 0);
    chk({tag, "_start_we"}, bus.we, 0);
    tick();
  endtask

  task automatic byte_chk(input string tag, input logic ack, input logic [31:0] addr,
                          input logic mwe, input logic [7:0] wb, input logic [7:0] rb);
    bus.mem_ack = ack; bus.mem_rdata = rb;
    #1;
    chk({tag, "_req"}, bus.mem_req, bus.rdy | 1'b1);
    chk({tag, "_addr"}, bus.mem_addr, addr);
    chk({tag, "_mwe"}, bus.mem_we, mwe);
    if (mwe) chk({tag, "_mwdata"}, bus.mem_wdata, wb);
    chk({tag, "_stall"}, bus.stall_req, 1);
    chk({tag, "_we"}, bus.we, 0);
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
  endtask

  task automatic done_chk(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd);
    #1;
    chk({tag, "_done_stall"}, bus.stall_req, 0);
    chk({tag, "_done_req"}, bus.mem_req, 0);
    chk({tag, "_done_we"}, bus.we, we);
    chk({tag, "_done_waddr"}, bus.waddr, wa);
    chk({tag, "_done_wdata"}, bus.wdata, wd);
    tick();
  endtask

  initial begin
    rst = 1'b1; bus.rdy = 1'b1; bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    set_op(1, 0, 3'b010, 32'h40, 32'hFFFF_FFFF, 1, 5'd3, 32'h77);
    tick(); tick();
    chk("rst_stall", bus.stall_req, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst = 1'b0;
    set_op(0, 0, 3'b000, 0, 0, 1, 5'd5, 32'h1234);
    bus.mem_ack = 1'b1;
    #1;
    chk("alu_we", bus.we, 1);
    chk("alu_waddr", bus.waddr, 5);
    chk("alu_wdata", bus.wdata, 32'h1234);
    chk("alu_stall", bus.stall_req, 0);
    chk("alu_req", bus.mem_req, 0);
    tick();
    bus.mem_ack = 1'b0;
    // LW: 1 + 4 stall cycles then DONE
    set_op(0, 1, 3'b010, 32'h100, 0, 1, 5'd7, 32'hDEAD);
    start_chk("lw");
    byte_chk("lw_b0", 1, 32'h100, 0, 0, 8'h78);
    byte_chk("lw_b1", 1, 32'h101, 0, 0, 8'h56);
    byte_chk("lw_b2", 1, 32'h102, 0, 0, 8'h34);
    byte_chk("lw_b3", 1, 32'h103, 0, 0, 8'h12);
    done_chk("lw", 1, 5'd7, 32'h1234_5678);
    set_op(0, 1, 3'b000, 32'h200, 0, 1, 5'd3, 0);
    start_chk("lb");
    byte_chk("lb_b0", 1, 32'h200, 0, 0, 8'h80);
    done_chk("lb", 1, 5'd3, 32'hFFFF_FF80);
    // rdy low in IDLE must not start the access
    set_op(0, 1, 3'b100, 32'h200, 0, 1, 5'd4, 0);
    bus.rdy = 1'b0;
    tick();
    bus.rdy = 1'b1;
    start_chk("lbu");
    byte_chk("lbu_b0", 1, 32'h200, 0, 0, 8'h80);
    done_chk("lbu", 1, 5'd4, 32'h0000_0080);
    set_op(1, 0, 3'b001, 32'h3, 32'hAABB_CCDD, 0, 5'd0, 32'h55);
    start_chk("sh");
    byte_chk("sh_b0", 1, 32'h3, 1, 8'hDD, 0);
    byte_chk("sh_b1", 1, 32'h4, 1, 8'hCC, 0);
    done_chk("sh", 0, 5'd0, 32'h55);
    set_op(0, 1, 3'b010, 32'h10, 0, 1, 5'd8, 0);
    start_chk("stl");
    byte_chk("stl_b0", 1, 32'h10, 0, 0, 8'h11);
    for (int i = 0; i < 3; i++) byte_chk("stl_wait", 0, 32'h11, 0, 0, 8'hEE);
    byte_chk("stl_b1", 1, 32'h11, 0, 0, 8'h22);
    bus.rdy = 1'b0;
    for (int i = 0; i < 2; i++) byte_chk("stl_frz", 1, 32'h12, 0, 0, 8'hEE);
    bus.rdy = 1'b1;
    byte_chk("stl_b2", 1, 32'h12, 0, 0, 8'h33);
    byte_chk("stl_b3", 1, 32'h13, 0, 0, 8'h44);
    done_chk("stl", 1, 5'd8, 32'h4433_2211);
    set_op(0, 1, 3'b001, 32'hFFFF_FFFF, 0, 1, 5'd9, 0);
    start_chk("wrap");
    byte_chk("wrap_b0", 1, 32'hFFFF_FFFF, 0, 0, 8'h34);
    byte_chk("wrap_b1", 1, 32'h0000_0000, 0, 0, 8'h82);
    done_chk("wrap", 1, 5'd9, 32'hFFFF_8234);
    set_op(1, 0, 3'b010, 32'h20, 32'h0102_0304, 0, 5'd0, 0);
    start_chk("sw");
    byte_chk("sw_b0", 1, 32'h20, 1, 8'h04, 0);
    byte_chk("sw_b1", 1, 32'h21, 1, 8'h03, 0);
    rst = 1'b1;
    #1;
    chk("sw_rst_stall", bus.stall_req, 0);
    chk("sw_rst_req", bus.mem_req, 0);
    chk("sw_rst_mwdata", bus.mem_wdata, 0);
    tick();
    rst = 1'b0;
    set_op(0, 0, 3'b000, 0, 0, 1, 5'd9, 32'hCAFE);
    #1;
    chk("post_rst_stall", bus.stall_req, 0);
    chk("post_rst_req", bus.mem_req, 0);
    chk("post_rst_we", bus.we, 1);
    chk("post_rst_waddr", bus.waddr, 9);
    chk("post_rst_wdata", bus.wdata, 32'hCAFE);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
